gray_counter_n: RTL and testbench

GRAY_COUNTER_N -- requirements
Module: gray_counter_n

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray2bin_n.sv | 15 +
 rtl/gray_counter_n.sv | 67 ++++++
 tb/tb_gray_counter_n.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter end-of-range mode constants.
package gray_pkg;

    localparam int MAX_W = 16;
    localparam int WRAP  = 0;
    localparam int SAT   = 1;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter for an arbitrary width up to 16.
module gray2bin_n
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = WIDTH'(gray2bin(MAX_W'(gray_i)));
    end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray counter with load, terminal count and wrap pulse.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;

    gray2bin_n #(.WIDTH(WIDTH)) u_load_g2b (
        .gray_i (load_val),
        .bin_o  (load_bin)
    );

    always_comb begin
        tc = up ? (bin_q == '1) : (bin_q == '0);
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (SATURATE == SAT && tc) begin
                bin_d = bin_q;
            end else begin
                bin_d  = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
                // tc reflects the current direction, so it marks exactly the wrapping step
                wrap_d = (SATURATE == WRAP) && tc;
            end
        end
        gray_d = WIDTH'(bin2gray(MAX_W'(bin_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: wrapping and saturating instances, WIDTH=4.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] g0, b0, g1, b1;
    logic       tc0, w0, tc1, w1;

    int checks = 0;
    int errors = 0;

    // Hand-written 4-bit reflected Gray sequence, indexed by binary value.
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    typedef struct {
        string      name;
        int         sel;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       wrap;
        logic       tc;
        bit         onebit;
    } exp_t;

    exp_t q[$];

    gray_counter_n #(.WIDTH(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_out(g0), .bin_out(b0), .tc(tc0), .wrap(w0)
    );

    gray_counter_n #(.WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_out(g1), .bin_out(b1), .tc(tc1), .wrap(w1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic e, input logic u, input logic l,
                        input logic [3:0] lv, input int sel, input logic [3:0] eb,
                        input logic ew, input logic etc, input bit ob);
        exp_t it;
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv;
        it.name = nm; it.sel = sel; it.bin = eb; it.gray = gtab[eb];
        it.wrap = ew; it.tc = etc; it.onebit = ob;
        q.push_back(it);
    endtask

    // Monitor: every registered update is compared against the oldest expectation.
    initial begin
        exp_t it;
        logic [3:0] prev [2];
        logic [3:0] g, b;
        logic       w, t;
        prev[0] = '0;
        prev[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                if (it.sel == 0) begin g = g0; b = b0; w = w0; t = tc0; end
                else             begin g = g1; b = b1; w = w1; t = tc1; end
                chk({it.name, "_bin"},  32'(b), 32'(it.bin));
                chk({it.name, "_gray"}, 32'(g), 32'(it.gray));
                chk({it.name, "_wrap"}, 32'(w), 32'(it.wrap));
                chk({it.name, "_tc"},   32'(t), 32'(it.tc));
                if (it.onebit)
                    chk({it.name, "_onebit"}, 32'($countones(g ^ prev[it.sel])), 32'd1);
                prev[0] = g0;
                prev[1] = g1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, both instances, tc follows ~up during reset.
        #2;
        chk("rst_bin0", 32'(b0), 0);  chk("rst_gray0", 32'(g0), 0);
        chk("rst_wrap0", 32'(w0), 0); chk("rst_bin1", 32'(b1), 0);
        chk("rst_tc_up1", 32'(tc0), 0);
        up = 1'b0; #1;
        chk("rst_tc_up0", 32'(tc0), 1);
        chk("rst_tc_up0_sat", 32'(tc1), 1);
        up = 1'b1;
        @(negedge clk); rst_n = 1'b1;

        for (int k = 1; k <= 16; k++)
            step("up_wrap", 1, 1, 0, 4'd0, 0, 4'(k % 16), k == 16, (k % 16) == 15, 1);

        step("ld3",   0, 0, 1, 4'b0010, 0, 4'd3,  0, 0, 0);
        step("dn2",   1, 0, 0, 4'd0,    0, 4'd2,  0, 0, 1);
        step("dn1",   1, 0, 0, 4'd0,    0, 4'd1,  0, 0, 1);
        step("dn0",   1, 0, 0, 4'd0,    0, 4'd0,  0, 1, 1);
        step("dn15",  1, 0, 0, 4'd0,    0, 4'd15, 1, 0, 1);

        step("ld8",      1, 1, 1, 4'b1100, 0, 4'd8, 0, 0, 0);
        step("after_ld", 1, 1, 0, 4'd0,    0, 4'd9, 0, 0, 1);

        step("ld15",     0, 1, 1, 4'b1000, 0, 4'd15, 0, 1, 0);
        step("ld_at_tc", 1, 1, 1, 4'b0000, 0, 4'd0,  0, 0, 0);

        step("ld5",   0, 1, 1, 4'b0111, 0, 4'd5, 0, 0, 0);
        step("tog6a", 1, 1, 0, 4'd0,    0, 4'd6, 0, 0, 1);
        step("tog5a", 1, 0, 0, 4'd0,    0, 4'd5, 0, 0, 1);
        step("tog6b", 1, 1, 0, 4'd0,    0, 4'd6, 0, 0, 1);
        step("tog5b", 1, 0, 0, 4'd0,    0, 4'd5, 0, 0, 1);

        step("ld6",  0, 1, 1, 4'b0101, 0, 4'd6, 0, 0, 0);
        step("hold", 0, 1, 0, 4'd0,    0, 4'd6, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bin",  32'(b0), 0);
        chk("async_rst_gray", 32'(g0), 0);
        chk("async_rst_wrap", 32'(w0), 0);
        chk("async_rst_tc",   32'(tc0), 0);
        #1 rst_n = 1'b1;
        step("resume1", 1, 1, 0, 4'd0, 0, 4'd1, 0, 0, 0);
        step("resume2", 1, 1, 0, 4'd0, 0, 4'd2, 0, 0, 1);
        step("resume3", 1, 1, 0, 4'd0, 0, 4'd3, 0, 0, 1);

        for (int k = 4; k <= 15; k++)
            step("sat_up", 1, 1, 0, 4'd0, 1, 4'(k), 0, k == 15, 1);
        for (int k = 0; k < 3; k++)
            step("sat_hold", 1, 1, 0, 4'd0, 1, 4'd15, 0, 1, 0);
        step("sat_ld0", 0, 0, 1, 4'b0000, 1, 4'd0, 0, 1, 0);
        step("sat_dn0", 1, 0, 0, 4'd0,    1, 4'd0, 0, 1, 0);
        step("sat_dn0", 1, 0, 0, 4'd0,    1, 4'd0, 0, 1, 0);

        @(negedge clk); en = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
